// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU engine owning HI/LO, one bit per cycle.
// Optional MULTDIV_EARLY_TERM_EN skips iteration for zero multiplies and divide-by-zero.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t           state;
  logic [1:0]       op_r;
  logic             s1, s2;
  logic [WIDTH-1:0] a, b;
  logic [2*WIDTH-1:0] p;
  logic [CW-1:0]    cnt;
  logic             in_s1, in_s2, early, ge, dz;
  logic [WIDTH-1:0] abs1, abs2, r, fix_hi, fix_lo;
  logic [WIDTH:0]   msum, rsh, rdiff;
  logic [2*WIDTH-1:0] p_next, prod;
  always_comb begin
    in_s1 = ~op[0] & data1[WIDTH-1];
    in_s2 = ~op[0] & data2[WIDTH-1];
    abs1 = in_s1 ? -data1 : data1;
    abs2 = in_s2 ? -data2 : data2;
`ifdef MULTDIV_EARLY_TERM_EN
    early = op[1] ? (data2 == '0) : (data1 == '0 || data2 == '0);
`else
    early = 1'b0;
`endif
    msum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, a} : '0);
    rsh = p[2*WIDTH-1:WIDTH-1];
    ge = rsh >= {1'b0, b};
    rdiff = rsh - {1'b0, b};
    p_next = op_r[1] ? {ge ? rdiff[WIDTH-1:0] : rsh[WIDTH-1:0], p[WIDTH-2:0], ge}
                     : {msum, p[WIDTH-1:1]};
    dz = b == '0;
    prod = (s1 ^ s2) ? -p : p;
    r = dz ? a : p[2*WIDTH-1:WIDTH];
    fix_hi = op_r[1] ? (s1 ? -r : r) : prod[2*WIDTH-1:WIDTH];
    fix_lo = op_r[1] ? (dz ? '1 : ((s1 ^ s2) ? -p[WIDTH-1:0] : p[WIDTH-1:0])) : prod[WIDTH-1:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      hi <= '0;
      lo <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      div_by_zero <= 1'b0;
      cnt <= '0;
      op_r <= '0;
      s1 <= 1'b0;
      s2 <= 1'b0;
      a <= '0;
      b <= '0;
      p <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            op_r <= op;
            s1 <= in_s1;
            s2 <= in_s2;
            a <= abs1;
            b <= abs2;
            p <= early ? '0 : {{WIDTH{1'b0}}, op[1] ? abs1 : abs2};
            cnt <= CW'(WIDTH);
            busy <= 1'b1;
            state <= early ? FIX : CALC;
          end
        end
        CALC: begin
          p <= p_next;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
          hi <= fix_hi;
          lo <= fix_lo;
          done <= 1'b1;
          busy <= 1'b0;
          if (op_r[1]) div_by_zero <= dz;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vectors with hand-computed results for mult_div_unit.
module tb_mult_div_unit;
  logic clk = 0, rst = 1, start = 0, hi_we = 0, lo_we = 0;
  logic [1:0] op = 0;
  logic [31:0] data1 = 0, data2 = 0, wdata = 0;
  logic busy, done, div_by_zero;
  logic [31:0] hi, lo;
  int checks = 0, errors = 0, lat, bcnt, seen;
`ifdef MULTDIV_EARLY_TERM_EN
  localparam int LZ = 2;
`else
  localparam int LZ = 34;
`endif
  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .data1(data1), .data2(data2),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic run(input logic [1:0] o, input logic [31:0] d1, input logic [31:0] d2);
    @(negedge clk);
    start = 1; op = o; data1 = d1; data2 = d2;
    @(negedge clk);
    start = 0; lat = 1; bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_dz", {31'b0, div_by_zero}, 0);
    run(2'b00, 32'd7, 32'hFFFFFFFD);
    chk("mult_lat", lat, 34);
    chk("mult_busy_cycles", bcnt, 33);
    chk("mult_busy_at_done", {31'b0, busy}, 0);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFEB);
    @(negedge clk);
    chk("done_one_cycle", {31'b0, done}, 0);
    run(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("multu_hi", hi, 32'hFFFFFFFE);
    chk("multu_lo", lo, 32'h00000001);
    run(2'b10, 32'hFFFFFFF9, 32'd2);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);
    run(2'b11, 32'd100, 32'd7);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);
    chk("divu_dz", {31'b0, div_by_zero}, 0);
    run(2'b11, 32'd5, 32'd0);
    chk("dz_lat", lat, LZ);
    chk("dz_lo", lo, 32'hFFFFFFFF);
    chk("dz_hi", hi, 32'd5);
    chk("dz_flag", {31'b0, div_by_zero}, 1);
    @(negedge clk);
    start = 1; op = 2'b01; data1 = 3; data2 = 4;
    @(negedge clk);
    start = 0; lat = 1;
    while (lat < 10) begin @(negedge clk); lat++; end
    start = 1; op = 2'b10; data1 = 100; data2 = 0; hi_we = 1; wdata = 32'hAAAA;
    @(negedge clk);
    start = 0; hi_we = 0; lat++;
    chk("busy_hi_hold", hi, 32'd5);
    while (!done && lat < 100) begin @(negedge clk); lat++; end
    chk("ign_lat", lat, 34);
    chk("ign_hi", hi, 0);
    chk("ign_lo", lo, 32'd12);
    chk("mul_keeps_dz", {31'b0, div_by_zero}, 1);
    @(negedge clk);
    chk("no_queue_busy", {31'b0, busy}, 0);
    run(2'b10, 32'h80000000, 32'hFFFFFFFF);
    chk("ovf_lo", lo, 32'h80000000);
    chk("ovf_hi", hi, 0);
    chk("ovf_dz", {31'b0, div_by_zero}, 0);
    run(2'b10, 32'hFFFFFFFB, 32'd0);
    chk("sdz_lat", lat, LZ);
    chk("sdz_lo", lo, 32'hFFFFFFFF);
    chk("sdz_hi", hi, 32'hFFFFFFFB);
    run(2'b01, 32'd0, 32'd5);
    chk("mzero_lat", lat, LZ);
    chk("mzero_hi", hi, 0);
    chk("mzero_lo", lo, 0);
    @(negedge clk);
    hi_we = 1; lo_we = 1; wdata = 32'h5555;
    start = 1; op = 2'b01; data1 = 6; data2 = 7;
    @(negedge clk);
    hi_we = 0; lo_we = 0; start = 0;
    chk("coincide_write", lo, 32'h5555);
    lat = 1;
    while (!done && lat < 100) begin @(negedge clk); lat++; end
    chk("coincide_lo", lo, 32'd42);
    chk("coincide_hi", hi, 0);
    @(negedge clk);
    start = 1; op = 2'b00; data1 = 9; data2 = 9;
    @(negedge clk);
    start = 0;
    repeat (13) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    seen = 0;
    repeat (40) begin @(negedge clk); if (done) seen++; end
    chk("abort_no_done", seen, 0);
    lo_we = 1; wdata = 32'h1234;
    @(negedge clk);
    lo_we = 0;
    chk("mtlo_lo", lo, 32'h1234);
    chk("mtlo_hi", hi, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
